// File: rtl/tbuf_arb_pkg.sv
// Shared types and defaults for the tristate-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the arbiter state enum and the default parameter values used by
// tbuf_bus_arb and tbuf_arb_rr_pick.
package tbuf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_TURNAROUND = 1;
  localparam int DEF_MAX_HOLD   = 8;

  // Width of the hold counter; covers the full MAX_HOLD range.
  localparam int HOLD_W = 8;

endpackage

// File: rtl/tbuf_arb_rr_pick.sv
// Round-robin one-hot picker, purely combinational.
// Latency: 0 cycles.
// Backpressure: none; the result is valid whenever any request is set.
//
// Ports:
//   req_i  - request vector
//   last_i - index of the previous owner; search starts at last_i+1
//   gnt_o  - one-hot winner (all zero when no request)
//   idx_o  - winner index (last_i when no request)
//   vld_o  - a winner exists
module tbuf_arb_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     vld_o
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] cand;

  // Walk the ring starting just after the last owner; the first set
  // request wins.  The last owner itself is checked last.
  always_comb begin
    gnt_o = '0;
    idx_o = last_i;
    vld_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last_i) + i) % N_REQ);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbuf_bus_arb.sv
// Arbiter for N_REQ tristate drivers sharing one bus, with turnaround gaps.
// Latency: grant one edge after REQ is seen in IDLE or at the end of TURN.
// Backpressure: requesters hold REQ until granted; owner holds the bus
//   until its REQ drops (or is preempted when TBUF_ARB_PREEMPT_EN is defined).
//
// Ports:
//   CLK  - rising-edge clock
//   R    - asynchronous active-low reset
//   REQ  - per-driver level request
//   EN   - registered one-hot/zero enable to the tristate buffers
//   GNT  - registered grant, same flop as EN
//   BUSY - registered, high whenever the state is not IDLE
//
// Build option: define TBUF_ARB_PREEMPT_EN to force the owner off the bus
// once it has held it MAX_HOLD cycles while another driver is waiting.
module tbuf_bus_arb
  import tbuf_arb_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic             CLK,
  input  logic             R,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] EN,
  output logic [N_REQ-1:0] GNT,
  output logic             BUSY
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);

  if (N_REQ < 2 || N_REQ > 8 || TURNAROUND < 1 || TURNAROUND > 15 ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
    $error("tbuf_bus_arb: parameter out of range");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] en_q, en_d;
  logic [IW-1:0]    last_q, last_d;   // current owner while in GRANT
  logic [3:0]       turn_q, turn_d;
  logic             armed_q;
  logic             busy_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic             arb_go;
  logic             drop;

`ifdef TBUF_ARB_PREEMPT_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  tbuf_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (REQ),
    .last_i (last_q),
    .gnt_o  (pick_oh),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    last_d  = last_q;
    turn_d  = turn_q;
    arb_go  = 1'b0;
    drop    = 1'b0;
`ifdef TBUF_ARB_PREEMPT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      // armed_q keeps the first edge after reset release from granting.
      IDLE: arb_go = armed_q;
      GRANT: begin
        drop = !REQ[last_q];
`ifdef TBUF_ARB_PREEMPT_EN
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        // hold_q counts completed GRANT cycles before the current one, so
        // HOLD_LAST here means this edge closes the MAX_HOLD-th cycle.
        if (hold_q >= HOLD_LAST && |(REQ & ~en_q)) drop = 1'b1;
`endif
        if (drop) begin
          state_d = TURN;
          en_d    = '0;
          turn_d  = TURN_LOAD;
        end
      end
      TURN: begin
        if (turn_q == 4'd0) arb_go = 1'b1;
        else                turn_d = turn_q - 4'd1;
      end
      default: begin
        state_d = IDLE;
        en_d    = '0;
      end
    endcase

    if (arb_go) begin
      if (pick_vld) begin
        state_d = GRANT;
        en_d    = pick_oh;
        last_d  = pick_idx;
`ifdef TBUF_ARB_PREEMPT_EN
        hold_d  = '0;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      en_q    <= '0;
      last_q  <= IW'(N_REQ - 1);
      turn_q  <= '0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TBUF_ARB_PREEMPT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
      armed_q <= 1'b1;
      busy_q  <= (state_d != IDLE);
`ifdef TBUF_ARB_PREEMPT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign EN   = en_q;
  assign GNT  = en_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_tbuf_bus_arb.sv
module tb_tbuf_bus_arb;

  localparam int N    = 4;
  localparam int TA   = 1;
  localparam int MAXH = 8;
`ifdef TBUF_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         R   = 1'b1;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] EN, GNT;
  logic         BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  tbuf_bus_arb #(.N_REQ(N), .TURNAROUND(TA), .MAX_HOLD(MAXH)) dut (
    .CLK  (CLK),
    .R    (R),
    .REQ  (REQ),
    .EN   (EN),
    .GNT  (GNT),
    .BUSY (BUSY)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = -1 means nobody holds the bus; gap counts bus-idle cycles still
  // owed after an owner leaves; held counts cycles the owner has had the bus.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_gap   = 0;
  int m_held  = 0;
  bit m_armed = 1'b0;

  function automatic logic [N-1:0] m_en();
    logic [N-1:0] v;
    v = '0;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  initial forever begin
    @(posedge CLK or negedge R);
    if (!R) begin
      m_owner = -1; m_last = N - 1; m_gap = 0; m_held = 0; m_armed = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
    end else if (m_owner >= 0) begin
      logic [N-1:0] others;
      others = REQ;
      others[m_owner] = 1'b0;
      m_held++;
      if (!REQ[m_owner] || (PREEMPT && m_held >= MAXH && others != 0)) begin
        m_owner = -1;
        m_gap   = TA;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && REQ[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_last  = m_owner;
          m_held  = 0;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  initial forever begin
    @(negedge CLK);
    check("model_en",   EN,   m_en());
    check("model_gnt",  GNT,  m_en());
    check("model_busy", BUSY, (m_owner >= 0) || (m_gap > 0));
    check("onehot0_en", $onehot0(EN), 1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b0; REQ = '0;
    tick(); tick();
    R = 1'b1;
    tick();   // first edge after release has passed
  endtask

  logic [N-1:0] seq [4];
  logic [N-1:0] nreq;

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;

    // Reset state and first grant latency.
    #2 R = 1'b0;
    tick();
    check("rst_en",   EN,   4'b0000);
    check("rst_gnt",  GNT,  4'b0000);
    check("rst_busy", BUSY, 1'b0);
    R = 1'b1;
    tick();                         // edge 1
    check("a_edge1_en", EN, 4'b0000);
    tick();                         // edge 2
    REQ = 4'b0001;
    tick();                         // edge 3
    check("a_edge3_en",   EN,   4'b0001);
    check("a_edge3_busy", BUSY, 1'b1);
    REQ = '0;
    tick();
    check("a_turn_en",   EN,   4'b0000);
    check("a_turn_busy", BUSY, 1'b1);
    tick();
    check("a_idle_busy", BUSY, 1'b0);

    // All four request together; each owner drops after 3 cycles.
    do_reset();
    REQ = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check("b_grant_en", EN, seq[k]);
      end
      REQ[k] = 1'b0;
      tick();
      check("b_gap_en", EN, 4'b0000);
    end
    tick();
    check("b_end_busy", BUSY, 1'b0);

    // Owner 0 keeps REQ while driver 2 waits.
    do_reset();
    REQ = 4'b0101;
    if (PREEMPT) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        check("c_hold_en", EN, 4'b0001);
      end
      tick();
      check("c_gap_en", EN, 4'b0000);
      tick();
      check("c_next_en", EN, 4'b0100);
    end else begin
      for (int c = 0; c < 12; c++) begin
        tick();
        check("c_hold_en", EN, 4'b0001);
      end
      REQ[0] = 1'b0;
      tick();
      check("c_gap_en", EN, 4'b0000);
      tick();
      check("c_next_en", EN, 4'b0100);
    end
    REQ = '0;
    tick(); tick();

    // Asynchronous reset in the middle of a grant.
    do_reset();
    REQ = 4'b0010;
    tick();
    check("d_grant_en", EN, 4'b0010);
    tick();
    R = 1'b0;
    #1;
    check("d_async_en",   EN,   4'b0000);
    check("d_async_busy", BUSY, 1'b0);
    #1 R = 1'b1;
    tick();                         // edge 1 after release: no grant yet
    check("d_edge1_en", EN, 4'b0000);
    tick();                         // edge 2
    check("d_regrant_en", EN, 4'b0010);
    REQ = '0;
    tick(); tick();

    // Randomized traffic, including non-owner withdrawals and reset pulses.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        R = 1'b0;
        #1;
        check("r_async_en", EN, 4'b0000);
        REQ = 4'($urandom_range(0, 15));
        tick();
        R = 1'b1;
      end else begin
        nreq = REQ;
        for (int b = 0; b < N; b++) begin
          if (EN[b]) begin
            if ($urandom_range(0, 11) == 0) nreq[b] = 1'b0;
          end else if (REQ[b]) begin
            if ($urandom_range(0, 9) == 0) nreq[b] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            nreq[b] = 1'b1;
          end
        end
        REQ = nreq;
      end
    end
    REQ = '0;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tbuf_bus_arb.md
TBUF_BUS_ARB -- requirements
Module: tbuf_bus_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of tristate drivers sharing one bus (2..8).
REQ-002 SHALL have parameter TURNAROUND, default 1, bus-idle cycles between owners (1..15).
REQ-003 SHALL have parameter MAX_HOLD, default 8, max grant cycles while others wait (2..255).
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 R  input  1  asynchronous active-low reset.
REQ-006 REQ  input  N_REQ  per-driver bus request, level, held for whole ownership.
REQ-007 EN  output  N_REQ  registered one-hot/zero enable to each TBUFX1/TBUFX2 EN pin.
REQ-008 GNT  output  N_REQ  registered grant, identical to EN.
REQ-009 BUSY  output  1  high when state is not IDLE.
REQ-010 Single clock domain (CLK); reset asynchronous and active-low (R).

Function
REQ-011 SHALL implement states IDLE, GRANT, TURN.
REQ-012 IDLE: any REQ bit set -> GRANT next edge; winner's EN/GNT bit high on that edge (1-cycle latency).
REQ-013 Winner SHALL be chosen round-robin: search starts at index (last_owner+1) mod N_REQ.
REQ-014 GRANT: owner REQ low -> EN all zero next edge, enter TURN.
REQ-015 TURN SHALL last exactly TURNAROUND cycles with EN all zero, then arbitrate as IDLE does (grant next edge if REQ pending, else IDLE).
REQ-016 EN SHALL never have more than one bit set in any cycle, including across owner changes.
REQ-017 Hold counter SHALL count owner's GRANT cycles, saturating at MAX_HOLD; cleared on entry to GRANT.
REQ-018 Non-owner REQ deasserted before being granted SHALL produce no grant.
REQ-019 Same owner re-requesting after TURN SHALL be granted only if no other REQ is pending, or by round-robin order.
REQ-020 REQ with N_REQ bits all set simultaneously SHALL grant in round-robin order, one owner per GRANT episode.

Reset
REQ-021 R low SHALL asynchronously force EN=0, GNT=0, BUSY=0, state IDLE, hold counter 0, last_owner=N_REQ-1 (index 0 highest priority after reset).
REQ-022 R asserted mid-GRANT or mid-TURN SHALL drop EN immediately, without waiting for CLK.
REQ-023 First grant after R release SHALL occur no earlier than the second rising CLK edge.

Configuration
REQ-024 Macro TBUF_ARB_PREEMPT_EN defined: in GRANT, hold counter = MAX_HOLD and any other REQ bit high -> EN all zero next edge, enter TURN, owner rejoins round-robin.
REQ-025 Macro undefined: no preemption, owner keeps bus until its REQ drops; hold counter omitted.

Structure
REQ-026 Shared package tbuf_arb_pkg SHALL hold state enum (IDLE, GRANT, TURN) and default parameter constants.
REQ-027 Round-robin one-hot picker SHALL be sub-module tbuf_arb_rr_pick (combinational; REQ vector + last_owner in, one-hot winner out).
REQ-028 All outputs SHALL be driven directly from flops; no combinational path REQ -> EN.

Verification (N_REQ=4, TURNAROUND=1, MAX_HOLD=8)
REQ-029 Reset release, REQ=0001 at edge 2 -> EN=0001 at edge 3, BUSY=1.
REQ-030 REQ=1111 held, each owner drops REQ after 3 cycles -> EN sequence 0001,0000,0010,0000,0100,0000,1000, each grant 3 cycles, 1 idle cycle between.
REQ-031 With TBUF_ARB_PREEMPT_EN, owner 0 holds REQ, REQ[2] rises -> EN=0001 for 8 cycles, 1 cycle 0000, then 0100.
REQ-032 Without TBUF_ARB_PREEMPT_EN, same stimulus -> EN=0001 until REQ[0] drops, then 0000, then 0100.
REQ-033 R pulsed low mid-GRANT (EN=0010) -> EN=0000 before next CLK edge; after release REQ=0010 -> EN=0010 regrant.
REQ-034 Every cycle of all scenarios: assertion EN one-hot-or-zero and EN==GNT.
